motion_skew_tx: RTL and testbench
=================================

Name: motion_skew_tx

Overview:
- Streaming generator for the inverse of the LiDAR deskew step. Takes world-frame (corrected) points plus a constant platform velocity and re-applies motion distortion: s = c - v*dt.
- Emits skewed points with the per-point dt in Q16.16, plus scan framing flags.
- Feeds the motion corrector in hardware loopback and round-trip regression, replacing file-driven stimulus.
- Pipelined with valid/ready handshakes on both sides.

Parameters:
- WP, 32, point/velocity/dt word width (signed Q16.16).
- FRAC, 16, fractional bits.
- PTS_PER_SCAN, 1024, points per scan; point index wraps here.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- scan_start  in  1  pulse; next accepted point becomes index 0.
- cfg_vx, cfg_vy, cfg_vz  in  WP  signed Q16.16 velocity.
- cfg_dt_step  in  WP  unsigned Q16.16 time between consecutive points.
- in_valid  in  1  input point valid.
- in_ready  out  1  block can accept a point.
- in_cx, in_cy, in_cz  in  WP  signed Q16.16 corrected point.
- out_valid  out  1  skewed point valid.
- out_ready  in  1  downstream accepts.
- out_sx, out_sy, out_sz  out  WP  signed Q16.16 skewed point.
- out_dt  out  WP  Q16.16 dt of this point.
- out_sof  out  1  point is index 0 of its scan.
- out_eof  out  1  point is index PTS_PER_SCAN-1.

Behaviour:
- Reset (async assert, sync release): all pipeline valids 0; out_valid=0; all out_* data=0; index=0; dt_acc=0; velocity/step latches=0. in_ready=1 from the first cycle after reset.
- Accept: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Index counter (log2 PTS_PER_SCAN bits):
  - Increments on each accept; wraps PTS_PER_SCAN-1 -> 0.
  - scan_start forces the point accepted in the same cycle, or the next accepted point if none is accepted that cycle, to index 0.
  - scan_start while the index is already 0 has no effect.
- Config latching: cfg_vx/vy/vz and cfg_dt_step are latched only when an index-0 point is accepted, so changing cfg mid-scan has no effect until the next scan.
- dt generation:
  - Index-0 point: dt=0.
  - Otherwise: dt = previous dt + latched step, unsigned add saturating at 0x7FFFFFFF.
  - dt is carried with the point through the pipeline.
- Stage 1 (registered): prod_k = v_k * dt as a 2WP signed product, then off_k = prod_k >>> FRAC (arithmetic shift, truncation toward -inf). off_k is kept at 2WP-FRAC bits.
- Stage 2 (registered):
  - diff_k = c_k - off_k, computed at 2WP-FRAC+1 bits.
  - Saturate to a WP signed value: >0x7FFFFFFF -> 0x7FFFFFFF; <0x80000000 -> 0x80000000.
  - sof/eof/dt pass through alongside.
- Latency: an accept in cycle N gives out_valid in cycle N+2 when out_ready stays high. Throughput is 1 point/cycle.
- Backpressure:
  - Each stage advances when its successor is empty or transferring.
  - in_ready = !s1_valid || s1 advancing; it is combinational from stage state and out_ready.
  - Output data holds stable while out_valid && !out_ready.
  - No drop, no duplication, order preserved.
  - At most 2 points in flight; in_ready=0 only when both stages are full and out_ready=0.
- Simultaneous scan_start and accept with index at PTS_PER_SCAN-1: the point gets index 0 (sof=1, eof=0).
- Reset mid-operation discards in-flight points. The first accept after reset is index 0 with dt=0.

Decomposition:
- Package motion_pkg:
  - WP/FRAC constants.
  - typedef q16_16_t (signed [WP-1:0]).
  - typedef point_t struct {x, y, z}.
  - Function sat_to_wp(signed wide) returning q16_16_t.
- One sub-module, skew_axis: stage-1 multiply/shift and stage-2 subtract/saturate for one axis, with an enable input. It is instantiated three times.
- The counter, dt accumulator, config latches and handshake control stay in motion_skew_tx.

Test Plan:
- Basic: vx=0x30000 (3.0), dt_step=6553 (~0.1). Points c=(0x10000,0,0) twice, out_ready=1.
  - Outputs at N+2 and N+3.
  - Point 0: sx=0x10000, dt=0, sof=1.
  - Point 1: dt=6553, sx=65536-19659=45877, sy=sz=0.
- Saturation: vx=0x10000, dt_step=0x10000, cx=0x80000000 on index 1 -> sx=0x80000000. Also vx=-0x10000, cx=0x7FFFFFFF -> sx=0x7FFFFFFF.
- Backpressure: out_ready=0 for 5 cycles while 4 points offered with distinct cx=1..4.
  - in_ready drops after 2 accepts.
  - out_sx is held stable.
  - After release, outputs appear in order 1,2,3,4 with none lost or duplicated.
- Wrap/framing: PTS_PER_SCAN=4, 9 points.
  - sof on points 0,4,8; eof on points 3,7.
  - dt restarts at 0 at each sof.
  - A cfg_vx change mid-scan is applied only from the next sof.
- scan_start: pulse concurrent with the accept of index 2 -> that point has sof=1, dt=0, and the following point has index 1.
- Reset mid-op: rst_n low for 1 cycle with 2 points in flight.
  - out_valid=0 immediately and outputs are zero.
  - Neither point ever appears.
  - Next accepted point has sof=1, dt=0.

Source files
------------

// File: rtl/motion_pkg.sv
// Shared types and helpers for the motion-skew point generator.
// All point, velocity and dt words are signed Q16.16.
package motion_pkg;

  localparam int WP   = 32;
  localparam int FRAC = 16;
  localparam int PW   = 2 * WP;          // full product width
  localparam int OW   = 2 * WP - FRAC;   // offset width after the fractional shift
  localparam int DW   = OW + 1;          // difference width, cannot overflow

  localparam logic [WP-1:0] DT_MAX = {1'b0, {(WP-1){1'b1}}};

  typedef logic signed [WP-1:0] q16_16_t;

  typedef struct packed {
    q16_16_t x;
    q16_16_t y;
    q16_16_t z;
  } point_t;

  // The value fits only when every bit above the result sign bit matches it.
  function automatic q16_16_t sat_to_wp(input logic signed [DW-1:0] d);
    if ((&d[DW-1:WP-1]) || !(|d[DW-1:WP-1]))
      return d[WP-1:0];
    return d[DW-1] ? {1'b1, {(WP-1){1'b0}}} : {1'b0, {(WP-1){1'b1}}};
  endfunction

endpackage

// File: rtl/motion_skew_tx_skew_axis.sv
// One axis of the skew datapath: stage 1 forms the motion offset v*dt,
// stage 2 subtracts it from the corrected coordinate and saturates.
module skew_axis
  import motion_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          advance,
  input  q16_16_t       v,
  input  logic [WP-1:0] dt,
  input  q16_16_t       c,
  output q16_16_t       s
);

  logic signed [OW-1:0] off_q;
  q16_16_t              c_q;
  logic signed [DW-1:0] diff;

  assign diff = DW'(c_q) - DW'(off_q);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q <= '0;
      c_q   <= '0;
      s     <= '0;
    end else begin
      if (load) begin
        // Arithmetic shift of the full product truncates toward -inf.
        off_q <= OW'((PW'(v) * PW'($signed(dt))) >>> FRAC);
        c_q   <= c;
      end
      if (advance)
        s <= sat_to_wp(diff);
    end
  end

endmodule

// File: rtl/motion_skew_tx.sv
// Re-applies constant-velocity motion distortion to world-frame points
// (s = c - v*dt) as a two-stage valid/ready pipeline with scan framing.
module motion_skew_tx
  import motion_pkg::*;
#(
  parameter int PTS_PER_SCAN = 1024
)
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scan_start,
  input  logic [WP-1:0] cfg_vx,
  input  logic [WP-1:0] cfg_vy,
  input  logic [WP-1:0] cfg_vz,
  input  logic [WP-1:0] cfg_dt_step,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WP-1:0] in_cx,
  input  logic [WP-1:0] in_cy,
  input  logic [WP-1:0] in_cz,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WP-1:0] out_sx,
  output logic [WP-1:0] out_sy,
  output logic [WP-1:0] out_sz,
  output logic [WP-1:0] out_dt,
  output logic          out_sof,
  output logic          out_eof
);

  localparam int IW = (PTS_PER_SCAN > 1) ? $clog2(PTS_PER_SCAN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(PTS_PER_SCAN - 1);

  logic [IW-1:0] idx_q;
  logic [IW-1:0] pt_idx;
  logic          start_pend;
  logic          pt_first;
  logic [WP-1:0] dt_q;
  logic [WP-1:0] step_q;
  logic [WP-1:0] pt_dt;
  logic [WP:0]   dt_sum;
  point_t        vel_q;
  point_t        cfg_vel;
  point_t        pt_vel;

  logic          s1_valid;
  logic          s1_sof;
  logic          s1_eof;
  logic [WP-1:0] s1_dt;
  logic          s2_free;
  logic          s1_fwd;
  logic          accept;
  q16_16_t       sx, sy, sz;

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;
  assign accept   = in_valid && in_ready;
  assign s1_fwd   = s1_valid && s2_free;

  assign cfg_vel = '{x: cfg_vx, y: cfg_vy, z: cfg_vz};

  // NOTE: every combinational output gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    pt_idx   = idx_q;
    pt_dt    = '0;
    dt_sum   = {1'b0, dt_q} + {1'b0, step_q};
    if (scan_start || start_pend)
      pt_idx = '0;
    pt_first = (pt_idx == '0);
    if (!pt_first)
      pt_dt = (dt_sum > {1'b0, DT_MAX}) ? DT_MAX : dt_sum[WP-1:0];
    // The index-0 point uses the configuration being latched in the same cycle.
    pt_vel = pt_first ? cfg_vel : vel_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      start_pend <= 1'b0;
      dt_q       <= '0;
      step_q     <= '0;
      vel_q      <= '0;
    end else if (accept) begin
      idx_q      <= (pt_idx == LAST_IDX) ? '0 : pt_idx + 1'b1;
      dt_q       <= pt_dt;
      start_pend <= 1'b0;
      if (pt_first) begin
        vel_q  <= cfg_vel;
        step_q <= cfg_dt_step;
      end
    end else if (scan_start) begin
      start_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sof    <= 1'b0;
      s1_eof    <= 1'b0;
      s1_dt     <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_dt    <= '0;
    end else begin
      if (in_ready)
        s1_valid <= accept;
      if (accept) begin
        s1_dt  <= pt_dt;
        s1_sof <= pt_first;
        s1_eof <= (pt_idx == LAST_IDX);
      end
      if (s2_free)
        out_valid <= s1_valid;
      if (s1_fwd) begin
        out_dt  <= s1_dt;
        out_sof <= s1_sof;
        out_eof <= s1_eof;
      end
    end
  end

  skew_axis u_axis_x (
    .clk(clk), .rst_n(rst_n), .load(accept), .advance(s1_fwd),
    .v(pt_vel.x), .dt(pt_dt), .c(in_cx), .s(sx)
  );

  skew_axis u_axis_y (
    .clk(clk), .rst_n(rst_n), .load(accept), .advance(s1_fwd),
    .v(pt_vel.y), .dt(pt_dt), .c(in_cy), .s(sy)
  );

  skew_axis u_axis_z (
    .clk(clk), .rst_n(rst_n), .load(accept), .advance(s1_fwd),
    .v(pt_vel.z), .dt(pt_dt), .c(in_cz), .s(sz)
  );

  assign out_sx = sx;
  assign out_sy = sy;
  assign out_sz = sz;

endmodule

// File: tb/tb_motion_skew_tx.sv
// Scoreboard bench for motion_skew_tx with a 4-point scan so wrap and
// framing are reachable with a handful of directed vectors.
module tb_motion_skew_tx;

  localparam int PTS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_start;
  logic [31:0] cfg_vx, cfg_vy, cfg_vz, cfg_dt_step;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_cx, in_cy, in_cz;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sx, out_sy, out_sz, out_dt;
  logic        out_sof, out_eof;

  always #5 clk = ~clk;

  motion_skew_tx #(.PTS_PER_SCAN(PTS)) dut (
    .clk(clk), .rst_n(rst_n), .scan_start(scan_start),
    .cfg_vx(cfg_vx), .cfg_vy(cfg_vy), .cfg_vz(cfg_vz), .cfg_dt_step(cfg_dt_step),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cx(in_cx), .in_cy(in_cy), .in_cz(in_cz),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sx(out_sx), .out_sy(out_sy), .out_sz(out_sz), .out_dt(out_dt),
    .out_sof(out_sof), .out_eof(out_eof)
  );

  typedef struct {
    logic [31:0] sx, sy, sz, dt;
    logic        sof, eof;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int          m_idx;
  bit          m_pend;
  logic [31:0] m_dt, m_step, m_vx, m_vy, m_vz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_axis(input logic [31:0] c, input logic [31:0] v,
                                           input logic [31:0] dt);
    longint lim = 64'sd2147483647;
    longint vv  = $signed(v);
    longint cc  = $signed(c);
    longint dd  = longint'(dt);
    longint off = (vv * dd) >>> 16;
    longint df  = cc - off;
    if (df > lim) return 32'h7FFFFFFF;
    if (df < -lim - 1) return 32'h80000000;
    return df[31:0];
  endfunction

  task automatic model_reset();
    m_idx = 0; m_pend = 1'b0; m_dt = '0; m_step = '0;
    m_vx = '0; m_vy = '0; m_vz = '0;
  endtask

  // Entered and left just after a rising edge; holds the point until accepted.
  task automatic send(input bit start, input logic [31:0] cx, input logic [31:0] cy,
                      input logic [31:0] cz);
    bit          acc = 1'b0;
    int          n = 0;
    int          idx;
    logic [31:0] dt;
    longint      s;
    exp_t        e;
    in_cx = cx; in_cy = cy; in_cz = cz;
    in_valid = 1'b1; scan_start = start;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #2;
      n++;
    end
    in_valid = 1'b0; scan_start = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected accept within 100 cycles cx=0x%08h", cx);
      return;
    end
    idx = (start || m_pend) ? 0 : m_idx;
    if (idx == 0) begin
      m_vx = cfg_vx; m_vy = cfg_vy; m_vz = cfg_vz; m_step = cfg_dt_step;
      dt = '0;
    end else begin
      s  = longint'(m_dt) + longint'(m_step);
      dt = (s > 64'sd2147483647) ? 32'h7FFFFFFF : s[31:0];
    end
    e.sx  = exp_axis(cx, m_vx, dt);
    e.sy  = exp_axis(cy, m_vy, dt);
    e.sz  = exp_axis(cz, m_vz, dt);
    e.dt  = dt;
    e.sof = (idx == 0);
    e.eof = (idx == PTS - 1);
    sb.push_back(e);
    m_dt   = dt;
    m_idx  = (idx == PTS - 1) ? 0 : idx + 1;
    m_pend = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got sx=0x%08h dt=0x%08h expected no output", out_sx, out_dt);
      end else begin
        e = sb.pop_front();
        check("out_sx", out_sx, e.sx);
        check("out_sy", out_sy, e.sy);
        check("out_sz", out_sz, e.sz);
        check("out_dt", out_dt, e.dt);
        check("out_sof", {31'b0, out_sof}, {31'b0, e.sof});
        check("out_eof", {31'b0, out_eof}, {31'b0, e.eof});
      end
    end
  end

  initial begin
    int n;
    scan_start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_cx = '0; in_cy = '0; in_cz = '0;
    cfg_vx = '0; cfg_vy = '0; cfg_vz = '0; cfg_dt_step = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_sx", out_sx, 32'd0);
    check("rst_out_dt", out_dt, 32'd0);
    check("rst_out_sof", {31'b0, out_sof}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Basic: 3.0 units/s, step ~0.1
    cfg_vx = 32'h0003_0000; cfg_dt_step = 32'd6553;
    send(1'b1, 32'h0001_0000, 32'h0, 32'h0);
    @(negedge clk);
    check("lat_n1_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_n2_valid", {31'b0, out_valid}, 32'd1);
    check("p0_sx", out_sx, 32'h0001_0000);
    check("p0_dt", out_dt, 32'd0);
    check("p0_sof", {31'b0, out_sof}, 32'd1);
    @(posedge clk);
    #2;
    send(1'b0, 32'h0001_0000, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("p1_sx", out_sx, 32'd45877);
    check("p1_dt", out_dt, 32'd6553);
    check("p1_sy", out_sy, 32'd0);
    @(posedge clk);
    #2;

    // Saturation, both signs
    cfg_vx = 32'h0001_0000; cfg_dt_step = 32'h0001_0000;
    send(1'b1, 32'h0, 32'h0, 32'h0);
    send(1'b0, 32'h8000_0000, 32'h0, 32'h0);
    cfg_vx = 32'hFFFF_0000;
    send(1'b1, 32'h0, 32'h0, 32'h0);
    send(1'b0, 32'h7FFF_FFFF, 32'h0, 32'h0);

    // Wrap/framing over 9 points with a mid-scan velocity change
    cfg_vx = 32'h0001_0000; cfg_vy = 32'h0000_8000; cfg_dt_step = 32'h0000_4000;
    send(1'b1, 32'h0, 32'h0001_0000, 32'h0);
    for (int i = 1; i < 9; i++) begin
      if (i == 2) cfg_vx = 32'h0002_0000;
      send(1'b0, i << 16, 32'h0001_0000, i);
    end

    // scan_start concurrent with the accept of index 2, then a pending pulse
    send(1'b1, 32'h0000_1000, 32'h0, 32'h0);
    send(1'b0, 32'h0000_2000, 32'h0, 32'h0);
    send(1'b1, 32'h0000_3000, 32'h0, 32'h0);
    send(1'b0, 32'h0000_4000, 32'h0, 32'h0);
    scan_start = 1'b1;
    @(posedge clk);
    #2;
    scan_start = 1'b0;
    m_pend = 1'b1;
    send(1'b0, 32'h0000_5000, 32'h0, 32'h0);

    // Backpressure with four distinct points
    repeat (3) @(posedge clk);
    #2;
    cfg_vx = '0; cfg_vy = '0; cfg_vz = '0;
    out_ready = 1'b0;
    send(1'b1, 32'd1, 32'h0, 32'h0);
    send(1'b0, 32'd2, 32'h0, 32'h0);
    fork
      begin
        send(1'b0, 32'd3, 32'h0, 32'h0);
        send(1'b0, 32'd4, 32'h0, 32'h0);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready", {31'b0, in_ready}, 32'd0);
          check("bp_hold_sx", out_sx, 32'd1);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #2;

    // Reset with two points in flight
    out_ready = 1'b0;
    send(1'b1, 32'd5, 32'h0, 32'h0);
    send(1'b0, 32'd6, 32'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_sx", out_sx, 32'd0);
    check("mid_rst_dt", out_dt, 32'd0);
    sb.delete();
    model_reset();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    send(1'b0, 32'd7, 32'h0, 32'h0);

    n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #2;
    check("drain_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
